// File: rtl/tc_pkg.sv
// Shared definitions for the TensorCore dot-product lane: FSM encoding,
// product width and the product sign-extension helper.
package tc_pkg;

  localparam int PROD_W = 16;
  localparam int EXT_W  = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  // Only the resolved product (sum+carry) may be extended; the redundant halves never are.
  function automatic logic signed [EXT_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(EXT_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/r4_mb8.sv
// Radix-4 Booth 8x8 signed multiplier, combinational, producing a carry-save
// pair whose modulo-2**16 sum is the exact product.
module r4_mb8
  import tc_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic signed [7:0]   x,
  input  logic signed [7:0]   y,
  output logic [PROD_W-1:0]   sum,
  output logic [PROD_W-1:0]   carry
);

  logic unused_pins;
  assign unused_pins = CLK ^ RST;

  function automatic logic [PROD_W-1:0] maj(input logic [PROD_W-1:0] a,
                                            input logic [PROD_W-1:0] b,
                                            input logic [PROD_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [8:0]                xe;
  logic signed [PROD_W-1:0]  ye;
  logic signed [PROD_W-1:0]  pp [4];
  logic [PROD_W-1:0]         s1, c1;

  assign xe = {x, 1'b0};

  always_comb begin
    ye = {{(PROD_W-8){y[7]}}, y};
    for (int i = 0; i < 4; i++) begin
      case (xe[2*i +: 3])
        3'b001, 3'b010: pp[i] = ye;
        3'b011:         pp[i] = ye <<< 1;
        3'b100:         pp[i] = -(ye <<< 1);
        3'b101, 3'b110: pp[i] = -ye;
        default:        pp[i] = '0;
      endcase
      pp[i] = pp[i] <<< (2*i);
    end
  end

  // Two levels of 3:2 compression reduce the four partial products to sum/carry.
  assign s1    = pp[0] ^ pp[1] ^ pp[2];
  assign c1    = maj(pp[0], pp[1], pp[2]) << 1;
  assign sum   = s1 ^ c1 ^ pp[3];
  assign carry = maj(s1, c1, pp[3]) << 1;

endmodule

// File: rtl/kulisch_dot_seq.sv
// Int8 dot-product sequencer: streams operand pairs through one Booth
// multiplier into a wide wrapping accumulator with sticky signed overflow.
module kulisch_dot_seq
  import tc_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_x,
  input  logic signed [7:0]       in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf
);

  function automatic logic add_ovf(input logic a_s, input logic b_s, input logic r_s);
    return (a_s == b_s) && (r_s != a_s);
  endfunction

  state_t                   state, state_nx;
  logic [LEN_W-1:0]         len_q, issued;
  logic                     hs, clr;

  logic signed [7:0]        x_p1, y_p1;
  logic                     vld_p1;
  logic [PROD_W-1:0]        mb_sum, mb_carry;
  logic [PROD_W-1:0]        sum_p2, carry_p2;
  logic                     vld_p2;

  logic [PROD_W-1:0]        prod;
  logic signed [EXT_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  addend, acc_sum, acc;
  logic                     ovf;
  logic                     unused_ext_hi;

  assign in_ready  = (state == RUN) && (issued < len_q);
  assign hs        = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_acc   = (state == DONE) ? acc : '0;
  assign out_ovf   = (state == DONE) && ovf;

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr      = 1'b1;
          state_nx = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs && (issued == len_q - 1'b1)) state_nx = DRAIN;
      end
      // The product held in stage 2 lands in acc on the same edge that enters DONE.
      DRAIN: begin
        if (!vld_p1) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      len_q  <= '0;
      issued <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      vld_p1 <= hs;
      vld_p2 <= vld_p1;
      if (clr) begin
        len_q  <= len;
        issued <= '0;
        acc    <= '0;
        ovf    <= 1'b0;
      end else begin
        if (hs) issued <= issued + 1'b1;
        if (vld_p2) begin
          acc <= acc_sum;
          if (add_ovf(acc[ACC_W-1], addend[ACC_W-1], acc_sum[ACC_W-1])) ovf <= 1'b1;
        end
      end
    end
  end

  // Stage 1: operand capture
  always_ff @(posedge CLK) begin
    if (hs) begin
      x_p1 <= in_x;
      y_p1 <= in_y;
    end
  end

  r4_mb8 u_mb (
    .CLK   (CLK),
    .RST   (RST),
    .x     (x_p1),
    .y     (y_p1),
    .sum   (mb_sum),
    .carry (mb_carry)
  );

  // Stage 2: carry-save product register
  always_ff @(posedge CLK) begin
    sum_p2   <= mb_sum;
    carry_p2 <= mb_carry;
  end

  // Stage 3: resolve product and accumulate
  always_comb begin
    prod     = sum_p2 + carry_p2;
    prod_ext = sext_prod(prod);
    addend   = prod_ext[ACC_W-1:0];
    acc_sum  = acc + addend;
  end

  assign unused_ext_hi = ^prod_ext;

endmodule

// File: tb/tb_kulisch_dot_seq.sv
// Scoreboard bench for kulisch_dot_seq: a 32-bit and a 16-bit accumulator
// instance share one stimulus bus selected by sel.
module tb_kulisch_dot_seq;

  typedef struct {
    logic signed [31:0] acc;
    logic               ovf;
  } exp_t;

  logic clk, rst, start, in_valid, out_ready, sel;
  logic [7:0] len;
  logic signed [7:0] in_x, in_y;

  logic a_start, a_in_valid, a_busy, a_in_ready, a_out_valid, a_out_ovf;
  logic b_start, b_in_valid, b_busy, b_in_ready, b_out_valid, b_out_ovf;
  logic signed [31:0] a_out_acc;
  logic signed [15:0] b_out_acc;

  logic busy_m, in_ready_m, out_valid_m, ovf_m;
  logic signed [31:0] acc_m;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  bit ready_seen = 0;

  logic signed [7:0] xv [8];
  logic signed [7:0] yv [8];

  assign a_start    = start & ~sel;
  assign b_start    = start & sel;
  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;

  assign busy_m      = sel ? b_busy      : a_busy;
  assign in_ready_m  = sel ? b_in_ready  : a_in_ready;
  assign out_valid_m = sel ? b_out_valid : a_out_valid;
  assign ovf_m       = sel ? b_out_ovf   : a_out_ovf;
  assign acc_m       = sel ? {{16{b_out_acc[15]}}, b_out_acc} : a_out_acc;

  kulisch_dot_seq #(.LEN_W(8), .ACC_W(32)) dut_a (
    .CLK(clk), .RST(rst), .start(a_start), .len(len), .busy(a_busy),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc), .out_ovf(a_out_ovf)
  );

  kulisch_dot_seq #(.LEN_W(8), .ACC_W(16)) dut_b (
    .CLK(clk), .RST(rst), .start(b_start), .len(len), .busy(b_busy),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc), .out_ovf(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Handshake counter and scoreboard monitor
  always @(negedge clk) begin
    if (in_valid && in_ready_m) hs_cnt++;
    if (in_ready_m) ready_seen = 1'b1;
    if (out_valid_m && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'sd1, 32'sd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_acc", acc_m, e.acc);
        check("out_ovf", {31'd0, ovf_m}, {31'd0, e.ovf});
      end
    end
  end

  task automatic do_job(input int n, input bit gaps, input bit sel_b,
                        input logic signed [31:0] e_acc, input bit e_ovf);
    int base, fed, last_cyc, start_cyc, done_cyc, guard;
    bit tog;
    exp_t e;
    sel = sel_b;
    e.acc = e_acc;
    e.ovf = e_ovf;
    sb.push_back(e);
    base = hs_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    fed = 0; guard = 0; tog = 1'b1; last_cyc = start_cyc;
    while (fed < n && guard < 200) begin
      in_valid = gaps ? tog : 1'b1;
      in_x     = in_valid ? xv[fed] : 8'sd77;
      in_y     = in_valid ? yv[fed] : -8'sd55;
      @(negedge clk);
      if (in_valid && in_ready_m) begin
        fed++;
        last_cyc = cyc;
      end
      @(posedge clk); #1;
      tog = ~tog;
      guard++;
    end
    in_valid = 1'b1;
    in_x = 8'sd99;
    in_y = 8'sd99;
    done_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_m) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("out_valid_seen", {31'd0, out_valid_m}, 32'sd1);
    check("latency", done_cyc - last_cyc, (n == 0) ? 1 : 3);
    check("handshakes", hs_cnt - base, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy_m) break;
    end
    check("idle", {31'd0, busy_m}, 32'sd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      {31'd0, a_busy | b_busy},           32'sd0);
    check({tag, "_in_ready"},  {31'd0, a_in_ready | b_in_ready},   32'sd0);
    check({tag, "_out_valid"}, {31'd0, a_out_valid | b_out_valid}, 32'sd0);
    check({tag, "_out_acc"},   a_out_acc | {{16{1'b0}}, b_out_acc}, 32'sd0);
    check({tag, "_out_ovf"},   {31'd0, a_out_ovf | b_out_ovf},     32'sd0);
  endtask

  initial begin
    logic signed [31:0] hold;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_x = '0; in_y = '0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-range products, continuous valid
    xv[0] = -8'sd128; xv[1] = 8'sd127; xv[2] = 8'sd3; xv[3] = -8'sd1;
    yv[0] = -8'sd128; yv[1] = 8'sd127; yv[2] = 8'sd5; yv[3] = 8'sd7;
    do_job(4, 1'b0, 1'b0, 32'sd32521, 1'b0);
    wait_idle();

    // Gapped valid
    xv[0] = 8'sd2; xv[1] = -8'sd3; xv[2] = 8'sd4;
    yv[0] = 8'sd5; yv[1] = 8'sd6;  yv[2] = -8'sd7;
    do_job(3, 1'b1, 1'b0, -32'sd36, 1'b0);
    wait_idle();

    // Zero-length job
    @(posedge clk); #1;
    ready_seen = 1'b0;
    do_job(0, 1'b0, 1'b0, 32'sd0, 1'b0);
    check("len0_in_ready_seen", {31'd0, ready_seen}, 32'sd0);
    wait_idle();

    // 16-bit accumulator overflow, then a clean job
    xv[0] = -8'sd128; xv[1] = -8'sd128;
    yv[0] = -8'sd128; yv[1] = -8'sd128;
    do_job(2, 1'b0, 1'b1, -32'sd32768, 1'b1);
    wait_idle();
    xv[0] = 8'sd1; yv[0] = 8'sd1;
    do_job(1, 1'b0, 1'b1, 32'sd1, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    sel = 1'b0;

    // Output stall with start pulsed during DONE
    out_ready = 1'b0;
    xv[0] = 8'sd3; xv[1] = 8'sd4;
    yv[0] = 8'sd2; yv[1] = 8'sd1;
    do_job(2, 1'b0, 1'b0, 32'sd10, 1'b0);
    hold = acc_m;
    check("stall_first_acc", hold, 32'sd10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      len = 8'd3;
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid_m}, 32'sd1);
      check("stall_acc", acc_m, hold);
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_idle_busy", {31'd0, busy_m}, 32'sd0);
    check("stall_idle_valid", {31'd0, out_valid_m}, 32'sd0);

    // Reset in RUN after two of four pairs
    @(posedge clk); #1;
    start = 1'b1; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_x = 8'sd9; in_y = 8'sd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midjob_busy", {31'd0, busy_m}, 32'sd1);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midjob_reset");
    xv[0] = 8'sd5; yv[0] = 8'sd5;
    do_job(1, 1'b0, 1'b0, 32'sd25, 1'b0);
    wait_idle();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'sd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
